// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex 7-segment display driver: segment bit
// positions and the active-high hex-to-segment table.
package hex_display_pkg;

  typedef logic [6:0] seg_t;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Glyphs use lowercase b and d so they stay distinct from 8 and 0.
  localparam seg_t HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to 7-segment lookup, active-high (bit0 = a .. bit6 = g).
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/hex_display_mux.sv
// Time-multiplexed hex display driver: shadowed value, slot prescaler, digit
// scan, leading-zero masking, anti-ghost blank window and registered outputs.
module hex_display_mux
  import hex_display_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int LZ_SUPPRESS    = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic          SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic          AN_INV  = (AN_ACTIVE_LOW != 0);

  logic [4*DIGITS-1:0] shadow;
  logic [DIGITS-1:0]   dp_shadow;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;

  logic [3:0]          nibs [DIGITS];
  logic                dps  [DIGITS];
  logic                lzs  [DIGITS];
  logic [DIGITS:0]     zero_from;
  logic [DIGITS-1:0]   an_sel;

  logic                in_window;
  logic                lit;
  logic [3:0]          cur_nib;
  seg_t                cur_seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      dp_shadow <= '0;
    end else if (load) begin
      shadow    <= value;
      dp_shadow <= dp_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // zero_from[i] is set when nibbles i..DIGITS-1 are all zero.
  assign zero_from[DIGITS] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign nibs[i]      = shadow[4*i +: 4];
    assign dps[i]       = dp_shadow[i];
    assign zero_from[i] = zero_from[i+1] & (shadow[4*i +: 4] == 4'h0);
    assign lzs[i]       = (LZ_SUPPRESS != 0) && (i > 0) && zero_from[i];
    assign an_sel[i]    = (idx == IW'(i));
  end

  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign in_window = 1'b1;
  end else begin : g_blank
    assign in_window = (cnt >= CW'(BLANK_CYCLES));
  end

  assign lit     = in_window & ~blank_in;
  assign cur_nib = nibs[idx];

  hex_seg_decode u_dec (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= {DIGITS{AN_INV}};
      seg <= {7{SEG_INV}};
      dp  <= SEG_INV;
    end else begin
      an  <= (lit ? an_sel : '0) ^ {DIGITS{AN_INV}};
      seg <= ((lit && !lzs[idx]) ? cur_seg : 7'h00) ^ {7{SEG_INV}};
      dp  <= (lit & dps[idx]) ^ SEG_INV;
    end
  end

endmodule

// File: tb/tb_hex_display_mux.sv
// Scoreboard bench for hex_display_mux: four parameterisations share stimulus,
// expectations come from a cycle model pushed at posedge and checked at negedge.
module tb_hex_display_mux;

  localparam logic [6:0] SEGTAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] c;
    logic [23:0] d;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_in;

  logic [6:0] seg_a, seg_b, seg_c, seg_d;
  logic       dp_a, dp_b, dp_c, dp_d;
  logic [3:0] an_a, an_b;
  logic [7:0] an_c;
  logic [0:0] an_d;

  int vectors = 0;
  int miscompares = 0;

  exp_t q[$];

  // Model state: shadow, plus cnt/idx for the div-4 and div-2 scans.
  logic [15:0] m_sh;
  logic [3:0]  m_dsh;
  int          c4, i4, c2, i8;

  hex_display_mux #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .LZ_SUPPRESS(0),
                    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .blank_in(blank_in), .seg(seg_a), .dp(dp_a), .an(an_a));

  hex_display_mux #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .LZ_SUPPRESS(1),
                    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .blank_in(blank_in), .seg(seg_b), .dp(dp_b), .an(an_b));

  hex_display_mux #(.DIGITS(8), .REFRESH_DIV(2), .BLANK_CYCLES(0), .LZ_SUPPRESS(0),
                    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_c (
    .clk(clk), .rst(rst), .value({value, value}), .dp_in({dp_in, dp_in}), .load(load),
    .blank_in(blank_in), .seg(seg_c), .dp(dp_c), .an(an_c));

  hex_display_mux #(.DIGITS(1), .REFRESH_DIV(2), .BLANK_CYCLES(0), .LZ_SUPPRESS(0),
                    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_d (
    .clk(clk), .rst(rst), .value(value[3:0]), .dp_in(dp_in[0:0]), .load(load),
    .blank_in(blank_in), .seg(seg_d), .dp(dp_d), .an(an_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {an[15:0], seg, dp} for a digit bank, active-low outputs.
  function automatic logic [23:0] model(input int nd, input int bc, input bit lz,
                                        input int c, input int ix, input logic [63:0] sh,
                                        input logic [15:0] dsh, input logic bl);
    logic [15:0] mask;
    logic [15:0] an_e;
    logic [6:0]  s;
    logic [3:0]  nib;
    mask = 16'((32'd1 << nd) - 1);
    if (bl || c < bc) return {mask, 7'h7F, 1'b1};
    nib = sh[ix*4 +: 4];
    s = SEGTAB[nib];
    if (lz && ix > 0 && (sh >> (4*ix)) == 64'd0) s = 7'h00;
    an_e = mask & ~(16'd1 << ix);
    return {an_e, ~s, ~dsh[ix]};
  endfunction

  always @(posedge clk) begin
    exp_t e;
    logic bl;
    bl = rst | blank_in;
    e.a = model(4, 1, 1'b0, c4, i4, {48'h0, m_sh}, {12'h0, m_dsh}, bl);
    e.b = model(4, 1, 1'b1, c4, i4, {48'h0, m_sh}, {12'h0, m_dsh}, bl);
    e.c = model(8, 0, 1'b0, c2, i8, {32'h0, m_sh, m_sh}, {8'h0, m_dsh, m_dsh}, bl);
    e.d = model(1, 0, 1'b0, c2, 0, {60'h0, m_sh[3:0]}, {15'h0, m_dsh[0]}, bl);
    q.push_back(e);
    if (rst) begin
      m_sh = '0; m_dsh = '0; c4 = 0; i4 = 0; c2 = 0; i8 = 0;
    end else begin
      if (c4 == 3) begin c4 = 0; i4 = (i4 == 3) ? 0 : i4 + 1; end
      else c4 = c4 + 1;
      if (c2 == 1) begin c2 = 0; i8 = (i8 == 7) ? 0 : i8 + 1; end
      else c2 = c2 + 1;
      if (load) begin m_sh = value; m_dsh = dp_in; end
    end
  end

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("inst_a", {12'h0, an_a, seg_a, dp_a}, e.a);
      chk("inst_b_lz", {12'h0, an_b, seg_b, dp_b}, e.b);
      chk("inst_c_d8", {8'h0, an_c, seg_c, dp_c}, e.c);
      chk("inst_d_d1", {15'h0, an_d, seg_d, dp_d}, e.d);
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load_value(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_sh = '0; m_dsh = '0; c4 = 0; i4 = 0; c2 = 0; i8 = 0;
    rst = 1'b1; value = '0; dp_in = '0; load = 1'b0; blank_in = 1'b0;
    run(3);
    rst = 1'b0;

    load_value(16'h1A9F, 4'b0000);
    run(37);

    // asynchronous reset in the middle of a slot
    rst = 1'b1;
    #1;
    chk("rst_async_an", {20'h0, an_a}, 24'h00000F);
    chk("rst_async_seg", {17'h0, seg_a}, 24'h00007F);
    chk("rst_async_dp", {23'h0, dp_a}, 24'h000001);
    step();
    step();
    rst = 1'b0;
    run(4);

    load_value(16'h1A9F, 4'b0000);
    run(18);

    // value changes without load must not reach the display
    value = 16'h0000;
    run(16);

    // load coinciding with the idx 2 -> 3 slot change
    for (int k = 0; k < 16 && !(i4 == 2 && c4 == 3); k++) step();
    load_value(16'h0000, 4'b0000);
    run(16);

    load_value(16'h0050, 4'b0000);
    run(20);
    load_value(16'h8000, 4'b0000);
    run(16);
    load_value(16'h0007, 4'b1001);
    run(16);

    load_value(16'h1A9F, 4'b0100);
    run(20);
    blank_in = 1'b1;
    run(10);
    blank_in = 1'b0;
    run(20);

    load_value(16'hC0DE, 4'b1010);
    run(20);
    load_value(16'h2B34, 4'b0011);
    blank_in = 1'b1;
    run(3);
    blank_in = 1'b0;
    run(20);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
